// File: rtl/router_ctrl.sv
// Packet-sequencing controller for the 1x3 router: header decode, write FSM, per-port read watchdogs.
// Optional build macro ROUTER_DROP_CNT_EN adds a saturating count of dropped address-3 headers.
module router_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int TCW     = 5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic [2:0] full,
    input  logic [2:0] empty,
    input  logic [2:0] read_enb,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic [2:0] vld_out,
    output logic [2:0] soft_reset,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy
`ifdef ROUTER_DROP_CNT_EN
    ,
    output logic [7:0] drop_count
`endif
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        LOAD_PARITY        = 3'd4,
        CHECK_PARITY_ERROR = 3'd5,
        FIFO_FULL_STATE    = 3'd6,
        LOAD_AFTER_FULL    = 3'd7
    } state_t;

    localparam logic [TCW-1:0] CNT_LAST = TCW'(TIMEOUT - 1);

    state_t         state_r;
    state_t         next_state_s;
    logic [1:0]     addr_r;
    logic [1:0]     next_addr_s;
    logic           hdr_ok_s;
    logic           next_wr_s;
    logic [TCW-1:0] cnt_r [3];

    function automatic logic [2:0] port_sel(input logic [1:0] a);
        logic [2:0] sel;
        case (a)
            2'd0:    sel = 3'b001;
            2'd1:    sel = 3'b010;
            2'd2:    sel = 3'b100;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

    assign vld_out   = ~empty;
    assign fifo_full = full[addr_r];
    assign hdr_ok_s  = pkt_valid && (data_in != 2'd3);

    // Next-state logic; a watchdog reset on the active port overrides every transition.
    always_comb begin
        next_state_s = state_r;
        if (soft_reset[addr_r]) begin
            next_state_s = DECODE_ADDRESS;
        end else begin
            case (state_r)
                DECODE_ADDRESS: begin
                    if (hdr_ok_s) begin
                        if (empty[data_in]) begin
                            next_state_s = LOAD_FIRST_DATA;
                        end else begin
                            next_state_s = WAIT_TILL_EMPTY;
                        end
                    end else begin
                        next_state_s = DECODE_ADDRESS;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (empty[addr_r]) begin
                        next_state_s = LOAD_FIRST_DATA;
                    end else begin
                        next_state_s = WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: next_state_s = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full) begin
                        next_state_s = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        next_state_s = LOAD_PARITY;
                    end else begin
                        next_state_s = LOAD_DATA;
                    end
                end
                LOAD_PARITY: next_state_s = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    if (fifo_full) begin
                        next_state_s = FIFO_FULL_STATE;
                    end else begin
                        next_state_s = DECODE_ADDRESS;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) begin
                        next_state_s = LOAD_AFTER_FULL;
                    end else begin
                        next_state_s = FIFO_FULL_STATE;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        next_state_s = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        next_state_s = LOAD_PARITY;
                    end else begin
                        next_state_s = LOAD_DATA;
                    end
                end
                default: next_state_s = DECODE_ADDRESS;
            endcase
        end
    end

    // Destination latch: only a valid header seen in DECODE_ADDRESS updates it.
    always_comb begin
        next_addr_s = addr_r;
        if ((state_r == DECODE_ADDRESS) && hdr_ok_s) begin
            next_addr_s = data_in;
        end else begin
            next_addr_s = addr_r;
        end
    end

    assign next_wr_s = (next_state_s == LOAD_DATA) || (next_state_s == LOAD_PARITY) ||
                       (next_state_s == LOAD_AFTER_FULL);

    // State register with Moore decodes registered alongside it so they track state exactly.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r     <= DECODE_ADDRESS;
            addr_r      <= 2'd0;
            detect_add  <= 1'b1;
            lfd_state   <= 1'b0;
            ld_state    <= 1'b0;
            laf_state   <= 1'b0;
            full_state  <= 1'b0;
            rst_int_reg <= 1'b0;
            busy        <= 1'b0;
            write_enb   <= 3'b000;
        end else begin
            state_r     <= next_state_s;
            addr_r      <= next_addr_s;
            detect_add  <= (next_state_s == DECODE_ADDRESS);
            lfd_state   <= (next_state_s == LOAD_FIRST_DATA);
            ld_state    <= (next_state_s == LOAD_DATA);
            laf_state   <= (next_state_s == LOAD_AFTER_FULL);
            full_state  <= (next_state_s == FIFO_FULL_STATE);
            rst_int_reg <= (next_state_s == CHECK_PARITY_ERROR);
            busy        <= !((next_state_s == DECODE_ADDRESS) || (next_state_s == LOAD_DATA));
            write_enb   <= next_wr_s ? port_sel(next_addr_s) : 3'b000;
        end
    end

    // Read watchdogs: a port left valid and unread for TIMEOUT cycles gets a one-cycle flush.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= '0;
            end
            soft_reset <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!vld_out[i] || read_enb[i]) begin
                    cnt_r[i]      <= '0;
                    soft_reset[i] <= 1'b0;
                end else if (cnt_r[i] == CNT_LAST) begin
                    cnt_r[i]      <= '0;
                    soft_reset[i] <= 1'b1;
                end else begin
                    cnt_r[i]      <= cnt_r[i] + TCW'(1);
                    soft_reset[i] <= 1'b0;
                end
            end
        end
    end

`ifdef ROUTER_DROP_CNT_EN
    // Saturating count of headers discarded for carrying the unused address 3.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            drop_count <= 8'd0;
        end else if ((state_r == DECODE_ADDRESS) && pkt_valid && (data_in == 2'd3) &&
                     (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end else begin
            drop_count <= drop_count;
        end
    end
`endif

endmodule
